md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit with HI/LO registers for the pipelined MIPS core, sitting in the E stage beside the ALU. It takes the 4-bit `xaluop` code produced by the instruction decoder and starts and times multi-cycle mult/multu/div/divu operations. It also services mthi/mtlo/mfhi/mflo and exports `start`/`busy` to the hazard unit, which stalls HI/LO-touching instructions in D.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).

- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `xaluop` input 4: E-stage op code. 8 mfhi, 7 mflo, 6 mult, 5 multu, 4 div, 3 divu, 2 mthi, 1 mtlo, 0 none, 9–15 treated as none.
- `a` input 32: rs operand, forwarded.
- `b` input 32: rt operand, forwarded.
- `start` output 1: combinational; high when `xaluop` is 3..6 and `busy`=0.
- `busy` output 1: registered; high while an operation is in flight.
- `hi` output 32: HI register.
- `lo` output 32: LO register.
- `md_out` output 32: combinational; `hi` if `xaluop`=8, `lo` if 7, else 0.

## Operation
- State: IDLE / RUN, counter `cnt` (≥ `$clog2(DIV_CYCLES+1)` bits), and pending result registers `p_hi`, `p_lo`.
- IDLE with `start`:
  - Compute the result from `a`, `b` into `p_hi`/`p_lo`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
  - Go to RUN.
- RUN: `cnt` decrements each cycle. On the edge where `cnt`=1, commit `p_hi`→`hi` and `p_lo`→`lo`, then go to IDLE.
- Arithmetic:
  - mult: {hi,lo} = signed(a)×signed(b), 64-bit.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient, truncated toward zero. hi = remainder, with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Division by zero is handled per Configuration.
- mthi/mtlo in IDLE: write `a` to hi/lo at the edge, single cycle, no busy.
- mthi/mtlo/mult/multu/div/divu while `busy`: ignored. The in-flight op is unaffected, and `start` stays 0. The hazard unit must prevent these cases, and the bench must check that they are ignored.
- mfhi/mflo: purely combinational read of the current `hi`/`lo`. During RUN these reads return the old values; stalling is the hazard unit's responsibility.
- Reset (any time, including mid-RUN): `hi`=`lo`=0, `busy`=0, `cnt`=0, IDLE, pending result discarded.

## Timing
- Edge 0: cycle with `start`=1; operands are sampled at this edge.
- `busy`=1 from the cycle after edge 0 for exactly N cycles (N = `MULT_CYCLES` or `DIV_CYCLES`), then 0.
- New `hi`/`lo` are visible in the first cycle with `busy`=0 after RUN.
- A new op may start in that same cycle, with no dead cycle between operations.
- `start`+`busy` together form the hazard-unit stall condition for D-stage md instructions.
- Reset values: `busy`=0, `hi`=0, `lo`=0. `start` and `md_out` follow `xaluop`.

## Configuration
- `MD_DIV0_HOLD_EN` defined:
  - div/divu with `b`=0 still runs the full `DIV_CYCLES` busy period.
  - `hi`/`lo` are left unchanged.
- `MD_DIV0_HOLD_EN` not defined, for div/divu with `b`=0:
  - lo=0xFFFFFFFF, hi=`a`. This applies to both signed and unsigned division.
  - Same timing as a normal division.

## Test plan
- Reset, then mult with a=0xFFFFFFFE (−2), b=3: `busy` high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu with a=0xFFFFFFFF, b=2: after 5 busy cycles, hi=1, lo=0xFFFFFFFE. Issue mfhi during `busy`: `md_out` shows the old hi (0).
- div with a=−7 (0xFFFFFFF9), b=2: `busy` high for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 7/2, then mtlo a=0x1234 in the first cycle after `busy` falls:
  - After the divu: lo=3, hi=1.
  - Next edge: lo=0x1234, with no busy.
  - Also issue mult while `busy`: ignored.
- div a=5, b=0:
  - With `MD_DIV0_HOLD_EN`: hi/lo unchanged after 10 cycles.
  - Without it: lo=0xFFFFFFFF, hi=5.
- Start div, assert `reset` at busy cycle 4: next cycle `busy`=0, hi=lo=0, and no later commit occurs.

Source files
------------

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage bundle between the pipeline and the multiply/divide unit.
//   xaluop, a, b      : op code and forwarded rs/rt operands (pipeline -> unit)
//   start, busy       : hazard-unit stall pair (unit -> pipeline)
//   hi, lo, md_out    : HI/LO registers and the mfhi/mflo read mux (unit -> pipeline)
// Modports: master = pipeline/testbench side, slave = md_unit side.
interface md_unit_if;
  logic [3:0]  xaluop;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (
    output xaluop, a, b,
    input  start, busy, hi, lo, md_out
  );

  modport slave (
    input  xaluop, a, b,
    output start, busy, hi, lo, md_out
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers (MIPS E stage).
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   md        : md_unit_if.slave (xaluop, a, b in; start, busy, hi, lo, md_out out)
//   dbg_state : current FSM state (0 = IDLE, 1 = RUN)
// Parameters: MULT_CYCLES / DIV_CYCLES = busy length of mult(u) / div(u).
// Optional feature: define MD_DIV0_HOLD_EN to keep hi/lo unchanged on a divide
// by zero; otherwise a divide by zero yields lo = 0xFFFFFFFF, hi = a.
//
// Handshake: an op is accepted on any rising edge where start = 1; start is
// high only for xaluop 3..6 while busy = 0. busy then stays high for exactly
// N cycles, and the result appears in hi/lo in the first cycle busy = 0, in
// which a new op may already be accepted. Ops arriving while busy are dropped.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   md,
  output logic       dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   p_hi_q, p_hi_d, p_lo_q, p_lo_d;

  logic        is_mult, is_div;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic [31:0] div0_hi, div0_lo;
  logic [31:0] res_hi, res_lo;

  assign is_mult  = (md.xaluop == 4'd6) || (md.xaluop == 4'd5);
  assign is_div   = (md.xaluop == 4'd4) || (md.xaluop == 4'd3);
  assign md.busy  = (state_q == S_RUN);
  assign md.start = (is_mult || is_div) && (state_q == S_IDLE);
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;
  assign dbg_state = state_q;

  always_comb begin
    md.md_out = 32'd0;
    if (md.xaluop == 4'd8)      md.md_out = hi_q;
    else if (md.xaluop == 4'd7) md.md_out = lo_q;
  end

  // Truncating 64-bit products; sign-extending first gives the signed result.
  assign prod_s = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};
  assign prod_u = {32'd0, md.a} * {32'd0, md.b};

  // Signed division on magnitudes: quotient sign = sign(a) xor sign(b),
  // remainder sign = sign(a). 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign a_mag = md.a[31] ? (~md.a + 32'd1) : md.a;
  assign b_mag = md.b[31] ? (~md.b + 32'd1) : md.b;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (md.a[31] ^ md.b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = md.a[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u   = md.a / md.b;
  assign r_u   = md.a % md.b;

`ifdef MD_DIV0_HOLD_EN
  // Pending result is the current HI/LO, so the commit leaves them unchanged
  // (mthi/mtlo cannot land while busy).
  assign div0_hi = hi_q;
  assign div0_lo = lo_q;
`else
  assign div0_hi = md.a;
  assign div0_lo = 32'hFFFF_FFFF;
`endif

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md.xaluop)
      4'd6: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      4'd5: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      4'd4: begin
        if (md.b == 32'd0) begin res_hi = div0_hi; res_lo = div0_lo; end
        else               begin res_hi = r_s;     res_lo = q_s;     end
      end
      4'd3: begin
        if (md.b == 32'd0) begin res_hi = div0_hi; res_lo = div0_lo; end
        else               begin res_hi = r_u;     res_lo = q_u;     end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    if (state_q == S_IDLE) begin
      if (md.start) begin
        p_hi_d  = res_hi;
        p_lo_d  = res_lo;
        cnt_d   = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        state_d = S_RUN;
      end else if (md.xaluop == 4'd2) begin
        hi_d = md.a;
      end else if (md.xaluop == 4'd1) begin
        lo_d = md.a;
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_d    = p_hi_q;
        lo_d    = p_lo_q;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed test of md_unit against an op-level reference model.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dbg_state;
  int   n_checks = 0;
  int   n_fail = 0;

  md_unit_if mdi();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md(mdi), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Tracks architectural HI/LO, the result of the op in flight and how many
  // busy cycles remain before it lands.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  int          m_left = 0;
  int          m_edges = 0;

  function automatic void ref_op(input logic [3:0] op, input logic [31:0] av, bv,
                                 input logic [31:0] cur_hi, cur_lo,
                                 output logic [31:0] rh, rl);
    longint      ps;
    longint unsigned pu;
    int          sa, sb;
    sa = av;
    sb = bv;
    rh = 32'd0;
    rl = 32'd0;
    if (op == 4'd6) begin
      ps = longint'(sa) * longint'(sb);
      rh = ps[63:32]; rl = ps[31:0];
    end else if (op == 4'd5) begin
      pu = {32'd0, av} * {32'd0, bv};
      rh = pu[63:32]; rl = pu[31:0];
    end else if (bv == 32'd0) begin
`ifdef MD_DIV0_HOLD_EN
      rh = cur_hi; rl = cur_lo;
`else
      rh = av; rl = 32'hFFFF_FFFF;
`endif
    end else if (op == 4'd4) begin
      if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
        rh = 32'd0; rl = 32'h8000_0000;
      end else begin
        rl = sa / sb; rh = sa % sb;
      end
    end else begin
      rl = av / bv; rh = av % bv;
    end
  endfunction

  always @(posedge clk) begin
    logic [31:0] rh, rl;
    m_edges <= m_edges + 1;
    if (reset) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin m_hi <= m_phi; m_lo <= m_plo; end
    end else if (mdi.xaluop >= 4'd3 && mdi.xaluop <= 4'd6) begin
      ref_op(mdi.xaluop, mdi.a, mdi.b, m_hi, m_lo, rh, rl);
      m_phi  <= rh;
      m_plo  <= rl;
      m_left <= (mdi.xaluop >= 4'd5) ? MC : DC;
    end else if (mdi.xaluop == 4'd2) begin
      m_hi <= mdi.a;
    end else if (mdi.xaluop == 4'd1) begin
      m_lo <= mdi.a;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic m_busy, m_start;
    logic [31:0] m_out;
    if (m_edges > 0) begin
      m_busy  = (m_left > 0);
      m_start = (mdi.xaluop >= 4'd3 && mdi.xaluop <= 4'd6) && !m_busy;
      m_out   = (mdi.xaluop == 4'd8) ? m_hi : (mdi.xaluop == 4'd7) ? m_lo : 32'd0;
      chk("cyc_busy",   {31'd0, mdi.busy},  {31'd0, m_busy});
      chk("cyc_start",  {31'd0, mdi.start}, {31'd0, m_start});
      chk("cyc_hi",     mdi.hi, m_hi);
      chk("cyc_lo",     mdi.lo, m_lo);
      chk("cyc_md_out", mdi.md_out, m_out);
    end
  end

  // Pins both the DUT and the model against hand-computed values.
  task automatic check_hl(input string name, input logic [31:0] eh, input logic [31:0] el);
    chk({name, "_hi"}, mdi.hi, eh);
    chk({name, "_lo"}, mdi.lo, el);
    chk({name, "_model_hi"}, m_hi, eh);
    chk({name, "_model_lo"}, m_lo, el);
  endtask

  // ---------------- drivers ----------------
  task automatic step(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    mdi.xaluop = op; mdi.a = av; mdi.b = bv;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 32'd0, 32'd0);
  endtask

  // Counts remaining busy cycles, bounded so a stuck busy cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (mdi.busy === 1'b1 && n < 50) begin
      n++;
      idle(1);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, eh, el;
  } vec_t;

  vec_t vecs[5];
  int   n;

  initial begin
    vecs[0] = '{4'd6, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[1] = '{4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{4'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[3] = '{4'd3, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999};
    vecs[4] = '{4'd4, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};

    mdi.xaluop = 4'd0; mdi.a = 32'd0; mdi.b = 32'd0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_busy", {31'd0, mdi.busy}, 32'd0);
    check_hl("rst", 32'd0, 32'd0);

    // mult -2 * 3
    step(4'd6, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    chk("mult_busy_len", n, MC);
    check_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // multu with an mfhi issued during busy
    reset = 1'b1; idle(1); reset = 1'b0;
    step(4'd5, 32'hFFFF_FFFF, 32'd2);
    mdi.xaluop = 4'd8; #1;
    chk("mfhi_during_busy", mdi.md_out, 32'd0);
    @(posedge clk); #1;
    wait_idle(n);
    chk("multu_busy_len", n, MC - 1);
    check_hl("multu", 32'h0000_0001, 32'hFFFF_FFFE);
    mdi.xaluop = 4'd7; #1;
    chk("mflo_after", mdi.md_out, 32'hFFFF_FFFE);
    @(posedge clk); #1;

    // div -7 / 2
    step(4'd4, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_busy_len", n, DC);
    check_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // divu 7/2 started in the first non-busy cycle; ops during busy are dropped
    mdi.xaluop = 4'd3; mdi.a = 32'd7; mdi.b = 32'd2; #1;
    chk("b2b_start", {31'd0, mdi.start}, 32'd1);
    @(posedge clk); #1;
    mdi.xaluop = 4'd6; mdi.a = 32'd3; mdi.b = 32'd3; #1;
    chk("start_while_busy", {31'd0, mdi.start}, 32'd0);
    @(posedge clk); #1;
    step(4'd2, 32'hDEAD_BEEF, 32'd0);
    wait_idle(n);
    chk("divu_busy_len", n, DC - 2);
    check_hl("divu", 32'd1, 32'd3);
    step(4'd1, 32'h0000_1234, 32'd0);
    chk("mtlo_busy", {31'd0, mdi.busy}, 32'd0);
    check_hl("mtlo", 32'd1, 32'h0000_1234);

    // signed overflow case
    step(4'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("ovf_busy_len", n, DC);
    check_hl("div_ovf", 32'd0, 32'h8000_0000);

    // table of additional vectors
    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(n);
      chk($sformatf("vec%0d_busy_len", i), n, (vecs[i].op >= 4'd5) ? MC : DC);
      check_hl($sformatf("vec%0d", i), vecs[i].eh, vecs[i].el);
    end

    // divide by zero (previous hi/lo: 0xFFFFFFFE / 0x2)
    step(4'd4, 32'd5, 32'd0);
    wait_idle(n);
    chk("div0_busy_len", n, DC);
`ifdef MD_DIV0_HOLD_EN
    check_hl("div0", 32'hFFFF_FFFE, 32'h0000_0002);
`else
    check_hl("div0", 32'd5, 32'hFFFF_FFFF);
`endif

    // reset in busy cycle 4 of a div
    step(4'd4, 32'd100, 32'd7);
    idle(3);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("midrst_busy", {31'd0, mdi.busy}, 32'd0);
    check_hl("midrst", 32'd0, 32'd0);
    idle(DC + 2);
    chk("midrst_late_busy", {31'd0, mdi.busy}, 32'd0);
    check_hl("midrst_late", 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
